imem_pl: RTL
============

IMEM_PL -- requirements
Module: imem_pl

Interface
REQ-001 SHALL have parameter INSN_W, default 32 (`INSN_LEN), instruction width in bits.
REQ-002 SHALL have parameter FETCH_WIDTH, default 4, instructions per memory line.
REQ-003 SHALL have parameter DEPTH, default 512, number of lines; ADDR_W = clog2(DEPTH).
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port rd_req  input  1  fetch request.
REQ-007 SHALL have port rd_addr  input  ADDR_W  line index to fetch.
REQ-008 SHALL have port rd_stall  input  1  downstream stall; hold output.
REQ-009 SHALL have port rd_valid  output  1  rd_data holds a fetched line.
REQ-010 SHALL have port rd_data  output  INSN_W*FETCH_WIDTH  fetched line, slot 0 in LSBs.
REQ-011 SHALL have port ld_start  input  1  begin a load session.
REQ-012 SHALL have port ld_base  input  ADDR_W  first line written by the session.
REQ-013 SHALL have port ld_valid  input  1  loader word present.
REQ-014 SHALL have port ld_last  input  1  qualifies ld_valid: final word of session.
REQ-015 SHALL have port ld_data  input  INSN_W  loader instruction word.
REQ-016 SHALL have port ld_ready  output  1  loader word accepted when ld_valid&ld_ready.
REQ-017 SHALL have port ld_busy  output  1  high while loader FSM is not IDLE.
REQ-018 SHALL have port ld_done  output  1  one-cycle pulse at session end.

Function
REQ-019 Read path SHALL have 1-cycle latency: rd_req=1, rd_stall=0 at edge N -> rd_data=mem[rd_addr], rd_valid=1 after edge N.
REQ-020 With rd_stall=0 and rd_req=0, rd_valid SHALL go 0 at next edge; rd_data holds last value.
REQ-021 With rd_stall=1, rd_valid and rd_data SHALL hold unchanged and rd_req SHALL be ignored.
REQ-022 Loader FSM states SHALL be IDLE, FILL, WRITE, DONE.
REQ-023 IDLE: ld_start=1 SHALL capture ld_base into line pointer, clear slot counter and staging line, go FILL; ld_start in any other state SHALL be ignored.
REQ-024 FILL: ld_ready=1; each accepted word SHALL be placed at staging slot = slot counter, counter increments.
REQ-025 FILL: acceptance filling slot FETCH_WIDTH-1, or any acceptance with ld_last=1, SHALL go WRITE.
REQ-026 Unfilled slots of a final partial line SHALL be written as zero.
REQ-027 WRITE: ld_ready=0; mem[line pointer] SHALL be written with staging line; pointer increments, wrapping DEPTH-1 -> 0; slot counter and staging cleared; go DONE if session last word seen, else FILL.
REQ-028 DONE: ld_done=1 for exactly one cycle, then IDLE.
REQ-029 ld_busy SHALL be 1 in FILL, WRITE, DONE; 0 in IDLE.
REQ-030 Reads SHALL proceed concurrently with loading; the read port is never blocked.
REQ-031 A read of the line being written in the same cycle SHALL return per REQ-040/REQ-041.

Reset
REQ-032 reset_n=0 SHALL immediately force rd_valid=0, rd_data=0, ld_ready=0, ld_busy=0, ld_done=0, FSM=IDLE, slot counter=0, line pointer=0.
REQ-033 Reset SHALL NOT initialise memory contents.
REQ-034 Reset mid-session SHALL discard the staged partial line; no write occurs for it.
REQ-035 Lines written before reset assertion SHALL retain their data.
REQ-036 After reset_n deasserts, first ld_start SHALL be honoured at the first rising edge.

Configuration
REQ-037 Macro IMEM_BYPASS_EN SHALL select read-during-write behaviour.
REQ-038 The macro SHALL affect only same-cycle same-address read/write collisions.
REQ-039 Memory array SHALL remain inferable as synchronous RAM in both builds.
REQ-040 Without IMEM_BYPASS_EN: colliding read SHALL return old line contents.
REQ-041 With IMEM_BYPASS_EN: colliding read SHALL return the line being written.

Verification
REQ-042 Reset, ld_start base=5, words 0x11,0x22,0x33,0x44,0x55(last) -> mem[5]=0x00000044_00000033_00000022_00000011, mem[6]=0x55 in slot0 zero elsewhere, ld_done one pulse, ld_busy 0 after.
REQ-043 Read addr 5 with rd_stall=0 -> next cycle rd_valid=1, rd_data=mem[5]; raise rd_stall 3 cycles with rd_addr=6 -> rd_data unchanged, then rd_stall=0 -> addr 6 data.
REQ-044 ld_start base=511, 8 words, last on 8th -> lines 511 and 0 written, line 1 untouched (wrap).
REQ-045 Write line 7 while rd_req addr 7 same cycle, old=0xA.., new=0xB.. -> old without IMEM_BYPASS_EN, new with it.
REQ-046 reset_n low after 2 of 4 words at base=9 -> mem[9] unchanged, all outputs 0 during reset, ld_start accepted after release.
REQ-047 ld_valid held 1 with gaps through WRITE -> no word lost or duplicated; ld_start during FILL ignored.

Source files
------------

// File: rtl/imem_pl.sv
// imem_pl: line-wide instruction memory with a 1-cycle stallable read port and a word-serial loader
// Optional build macro: IMEM_BYPASS_EN -- a read colliding with the line being written returns the new line
//   (default: returns the old line contents).
// Ports:
//   clk, reset_n            single clock, asynchronous active-low reset
//   rd_req, rd_addr         fetch request and line index
//   rd_stall                hold rd_valid/rd_data and ignore rd_req
//   rd_valid, rd_data       fetched line (slot 0 in LSBs), valid one cycle after request
//   ld_start, ld_base       begin a load session at line ld_base (honoured only when idle)
//   ld_valid, ld_last,      loader word handshake; ld_last marks the final word of the session
//   ld_data, ld_ready
//   ld_busy, ld_done        loader active / one-cycle end-of-session pulse
`ifndef INSN_LEN
`define INSN_LEN 32
`endif

module imem_pl #(
  parameter int INSN_W = `INSN_LEN,
  parameter int FETCH_WIDTH = 4,
  parameter int DEPTH = 512,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int LINE_W = INSN_W * FETCH_WIDTH
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_stall,
  output logic              rd_valid,
  output logic [LINE_W-1:0] rd_data,
  input  logic              ld_start,
  input  logic [ADDR_W-1:0] ld_base,
  input  logic              ld_valid,
  input  logic              ld_last,
  input  logic [INSN_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              ld_busy,
  output logic              ld_done
);
  localparam int SLOT_W = FETCH_WIDTH > 1 ? $clog2(FETCH_WIDTH) : 1;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(FETCH_WIDTH - 1);
  localparam logic [ADDR_W-1:0] LAST_LINE = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

  state_t state_q, state_d;
  logic [LINE_W-1:0] mem [DEPTH];
  logic [LINE_W-1:0] stage_q, stage_d, rd_data_q, rd_data_d, rd_line;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic last_q, last_d, rd_valid_q, rd_valid_d;
  logic ld_ready_q, ld_ready_d, ld_busy_q, ld_busy_d, ld_done_q, ld_done_d;
  logic wr_en, accept;

  assign wr_en = state_q == WRITE;
  // ld_ready_q is high exactly while in FILL, so it doubles as the FILL qualifier
  assign accept = ld_valid & ld_ready_q;

`ifdef IMEM_BYPASS_EN
  assign rd_line = (wr_en && ptr_q == rd_addr) ? stage_q : mem[rd_addr];
`else
  assign rd_line = mem[rd_addr];
`endif

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    slot_d = slot_q;
    ptr_d = ptr_q;
    last_d = last_q;
    case (state_q)
      IDLE: if (ld_start) begin
        state_d = FILL;
        ptr_d = ld_base;
        slot_d = '0;
        stage_d = '0;
        last_d = 1'b0;
      end
      FILL: if (accept) begin
        stage_d[slot_q*INSN_W +: INSN_W] = ld_data;
        slot_d = slot_q + 1'b1;
        if (ld_last || slot_q == LAST_SLOT) begin
          state_d = WRITE;
          last_d = ld_last;
        end
      end
      WRITE: begin
        ptr_d = ptr_q == LAST_LINE ? '0 : ptr_q + 1'b1;
        slot_d = '0;
        stage_d = '0;
        state_d = last_q ? DONE : FILL;
      end
      default: state_d = IDLE;
    endcase
    ld_ready_d = state_d == FILL;
    ld_busy_d = state_d != IDLE;
    ld_done_d = state_d == DONE;
    rd_valid_d = rd_stall ? rd_valid_q : rd_req;
    rd_data_d = (rd_stall || !rd_req) ? rd_data_q : rd_line;
  end

  // Memory has no reset so it stays inferable as synchronous RAM and survives reset
  always_ff @(posedge clk) begin
    if (wr_en) mem[ptr_q] <= stage_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      stage_q <= '0;
      slot_q <= '0;
      ptr_q <= '0;
      last_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q <= '0;
      ld_ready_q <= 1'b0;
      ld_busy_q <= 1'b0;
      ld_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      slot_q <= slot_d;
      ptr_q <= ptr_d;
      last_q <= last_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q <= rd_data_d;
      ld_ready_q <= ld_ready_d;
      ld_busy_q <= ld_busy_d;
      ld_done_q <= ld_done_d;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data = rd_data_q;
  assign ld_ready = ld_ready_q;
  assign ld_busy = ld_busy_q;
  assign ld_done = ld_done_q;
endmodule
